arcade_input_ctrl: RTL and testbench

Parametrised player-input and DIP-switch front end for arcade cores, placed between `hps_io` and `core` in `emu`. It captures DIP bytes and the title/layout byte from the ioctl stream and maps each player's 16-bit MiSTer joystick word to a registered 8-bit control byte. Direction layout is selected per title, and simultaneous opposing directions are resolved. Coin inputs are shaped into frame-timed pulses with re-trigger lockout, so one press cannot produce several credits.

---
 rtl/arcade_input_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
// Player-input and DIP-switch front end for arcade cores. It captures DIP
// bytes and the title/layout byte from the ioctl stream. It maps each
// player's MiSTer joystick word onto a registered control byte. It also turns
// raw coin inputs into frame-timed pulses, with a re-trigger lockout so that
// one press gives exactly one credit.
module arcade_input_ctrl #(
    parameter int PLAYERS     = 2,  // 1..4
    parameter int DIP_BYTES   = 8,  // 1..8
    parameter int COIN_FRAMES = 3,  // 1..15
    parameter int COIN_LOCK   = 2   // 0..15
) (
    input  logic                   clk_sys,
    input  logic                   reset,
    input  logic                   ioctl_wr,
    input  logic [7:0]             ioctl_index,
    input  logic [26:0]            ioctl_addr,
    input  logic [15:0]            ioctl_dout,
    input  logic                   vblank,
    input  logic [16*PLAYERS-1:0]  joy,
    output logic [8*PLAYERS-1:0]   pl,
    output logic [PLAYERS-1:0]     coin_out,
    output logic [8*DIP_BYTES-1:0] dsw,
    output logic [7:0]             layout,
    output logic                   dip_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PULSE = 2'd1,
        ST_HOLD  = 2'd2,
        ST_LOCK  = 2'd3
    } coin_state_t;

    localparam logic [3:0] C_FRAMES = 4'(COIN_FRAMES);
    localparam logic [3:0] C_LOCK   = 4'(COIN_LOCK);

    logic       r_vblank_d;
    logic [7:0] r_layout;
    logic       r_dip_valid;
    logic       w_vb_edge;
    logic       w_dip_wr;
    logic       w_layout_wr;
    logic       w_unused_io;

    // Only the low data byte is meaningful. Address bits above 24 take no
    // part in DIP decode.
    assign w_unused_io = ^{ioctl_addr[26:25], ioctl_dout[15:8]};

    assign w_vb_edge   = vblank & ~r_vblank_d;
    assign w_dip_wr    = ioctl_wr && (ioctl_index == 8'd254) && (ioctl_addr[24:3] == 22'd0);
    assign w_layout_wr = ioctl_wr && (ioctl_index == 8'd1);

    assign layout    = r_layout;
    assign dip_valid = r_dip_valid;

    // Delayed vblank for frame-edge detection
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_vblank_d <= 1'b0;
        end else begin
            r_vblank_d <= vblank;
        end
    end

    // Layout byte capture (last write wins) and the sticky DIP-valid flag
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_layout    <= 8'h00;
            r_dip_valid <= 1'b0;
        end else begin
            if (w_layout_wr) begin
                r_layout <= ioctl_dout[7:0];
            end
            if (w_dip_wr && (ioctl_addr[2:0] == 3'd0)) begin
                r_dip_valid <= 1'b1;
            end
        end
    end

    // One register per implemented DIP byte. Addresses with no byte behind
    // them match nothing, so they are dropped.
    generate
        for (genvar gi = 0; gi < DIP_BYTES; gi++) begin : g_dip
            logic [7:0] r_byte;

            // Capture this DIP byte when its address is written
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_byte <= 8'h00;
                end else if (w_dip_wr && (ioctl_addr[2:0] == 3'(gi))) begin
                    r_byte <= ioctl_dout[7:0];
                end
            end

            assign dsw[gi*8 +: 8] = r_byte;
        end
    endgenerate

    // Per-player control mapping and coin shaping
    generate
        for (genvar gi = 0; gi < PLAYERS; gi++) begin : g_player
            logic [15:0]  w_joy;
            logic         w_r;
            logic         w_l;
            logic         w_d;
            logic         w_u;
            logic [3:0]   w_dir;
            logic         w_coin_raw;
            logic         w_unused_joy;
            logic [7:0]   r_pl;
            coin_state_t  r_state;
            logic [3:0]   r_cnt;
            logic [3:0]   w_cnt_inc;
            logic         r_coin;

            assign w_joy        = joy[gi*16 +: 16];
            assign w_unused_joy = ^w_joy[15:9];
            assign w_coin_raw   = w_joy[8];

            // Opposing directions cancel before they are mapped to the layout
            assign w_r = w_joy[0] & ~w_joy[1];
            assign w_l = w_joy[1] & ~w_joy[0];
            assign w_d = w_joy[2] & ~w_joy[3];
            assign w_u = w_joy[3] & ~w_joy[2];

            assign w_dir = r_layout[0] ? {1'b0, w_d, 1'b0, w_u}
                                       : {w_l, 1'b0, w_r, 1'b0};

            // Frame counter saturates at 15 instead of wrapping
            assign w_cnt_inc = (r_cnt == 4'hF) ? r_cnt : r_cnt + 4'd1;

            // Registered control byte: {start, fire3, fire2, fire1, dir}
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_pl <= 8'h00;
                end else begin
                    r_pl <= {w_joy[7:4], w_dir};
                end
            end

            // Coin FSM: one pulse of COIN_FRAMES frames per press. The coin
            // must be released first, then a lockout of COIN_LOCK frames runs.
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 4'd0;
                    r_coin  <= 1'b0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            r_coin <= 1'b0;
                            if (w_coin_raw) begin
                                r_state <= ST_PULSE;
                                r_cnt   <= 4'd0;
                                r_coin  <= 1'b1;
                            end
                        end
                        ST_PULSE: begin
                            if (w_vb_edge) begin
                                r_cnt <= w_cnt_inc;
                                if (w_cnt_inc == C_FRAMES) begin
                                    r_state <= ST_HOLD;
                                    r_coin  <= 1'b0;
                                end
                            end
                        end
                        ST_HOLD: begin
                            r_coin <= 1'b0;
                            if (!w_coin_raw) begin
                                r_cnt   <= 4'd0;
                                r_state <= (COIN_LOCK == 0) ? ST_IDLE : ST_LOCK;
                            end
                        end
                        ST_LOCK: begin
                            r_coin <= 1'b0;
                            if (w_vb_edge) begin
                                r_cnt <= w_cnt_inc;
                                if (w_cnt_inc == C_LOCK) begin
                                    r_state <= ST_IDLE;
                                end
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 4'd0;
                            r_coin  <= 1'b0;
                        end
                    endcase
                end
            end

            assign pl[gi*8 +: 8] = r_pl;
            assign coin_out[gi]  = r_coin;
        end
    endgenerate

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Testbench for arcade_input_ctrl. Directed steps are mixed with randomized
// joystick, coin and ioctl traffic. Every cycle is checked against a
// behavioural model that counts frames remaining rather than states.
module tb_arcade_input_ctrl;

    localparam int NP    = 4;
    localparam int ND    = 4;
    localparam int CF    = 3;
    localparam int CL    = 2;
    localparam int FRAME = 10;

    logic            clk_sys = 1'b0;
    logic            reset;
    logic            ioctl_wr;
    logic [7:0]      ioctl_index;
    logic [26:0]     ioctl_addr;
    logic [15:0]     ioctl_dout;
    logic            vblank;
    logic [16*NP-1:0] joy;
    logic [8*NP-1:0] pl;
    logic [NP-1:0]   coin_out;
    logic [8*ND-1:0] dsw;
    logic [7:0]      layout;
    logic            dip_valid;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl #(
        .PLAYERS    (NP),
        .DIP_BYTES  (ND),
        .COIN_FRAMES(CF),
        .COIN_LOCK  (CL)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .ioctl_wr   (ioctl_wr),
        .ioctl_index(ioctl_index),
        .ioctl_addr (ioctl_addr),
        .ioctl_dout (ioctl_dout),
        .vblank     (vblank),
        .joy        (joy),
        .pl         (pl),
        .coin_out   (coin_out),
        .dsw        (dsw),
        .layout     (layout),
        .dip_valid  (dip_valid)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Stimulus sources
    logic [7:0] joy_base [NP];
    bit         coin_req [NP];

    // Reference model state
    logic [7:0] m_pl [NP];
    int         m_pulse_left [NP];
    bit         m_wait_rel [NP];
    int         m_lock_left [NP];
    bit         m_out [NP];
    logic [7:0] m_dsw [ND];
    logic [7:0] m_layout;
    bit         m_dipv;
    bit         m_vb_d;

    // Observation helpers
    int         rises [NP];
    int         hi_cnt [NP];
    logic [NP-1:0] prev_coin;

    function automatic logic [7:0] exp_pl(logic [15:0] j, logic [7:0] lay);
        int dir;
        bit r, l, d, u;
        r = j[0]; l = j[1]; d = j[2]; u = j[3];
        dir = 0;
        if (lay[0]) begin
            if (u && !d) dir += 1;
            if (d && !u) dir += 4;
        end else begin
            if (r && !l) dir += 2;
            if (l && !r) dir += 8;
        end
        return 8'(int'(j[7:4]) * 16 + dir);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model across one clock edge using the inputs now applied
    task automatic model_edge();
        bit vb_edge;
        bit c;
        logic [15:0] j;
        vb_edge = vblank && !m_vb_d;
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_pl[p] = 8'h00;
                m_pulse_left[p] = 0;
                m_wait_rel[p] = 0;
                m_lock_left[p] = 0;
                m_out[p] = 0;
            end
            for (int k = 0; k < ND; k++) m_dsw[k] = 8'h00;
            m_layout = 8'h00;
            m_dipv = 0;
            m_vb_d = 0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                j = joy[p*16 +: 16];
                c = j[8];
                m_pl[p] = exp_pl(j, m_layout);
                if (m_pulse_left[p] > 0) begin
                    if (vb_edge) begin
                        m_pulse_left[p]--;
                        if (m_pulse_left[p] == 0) begin
                            m_out[p] = 0;
                            m_wait_rel[p] = 1;
                        end
                    end
                end else if (m_wait_rel[p]) begin
                    if (!c) begin
                        m_wait_rel[p] = 0;
                        m_lock_left[p] = CL;
                    end
                end else if (m_lock_left[p] > 0) begin
                    if (vb_edge) m_lock_left[p]--;
                end else if (c) begin
                    m_pulse_left[p] = CF;
                    m_out[p] = 1;
                end
            end
            if (ioctl_wr && ioctl_index == 8'd1) m_layout = ioctl_dout[7:0];
            if (ioctl_wr && ioctl_index == 8'd254 && (ioctl_addr % 2**25) < ND) begin
                m_dsw[ioctl_addr % 8] = ioctl_dout[7:0];
                if ((ioctl_addr % 8) == 0) m_dipv = 1;
            end
            m_vb_d = vblank;
        end
    endtask

    // One clock: drive joy, update model, step, then compare everything
    task automatic tick();
        logic [8*NP-1:0] e_pl;
        logic [NP-1:0]   e_coin;
        logic [8*ND-1:0] e_dsw;
        for (int p = 0; p < NP; p++)
            joy[p*16 +: 16] = {7'($urandom), coin_req[p], joy_base[p]};
        model_edge();
        @(posedge clk_sys);
        #1;
        cyc++;
        vblank = ((cyc % FRAME) >= 7);
        for (int p = 0; p < NP; p++) begin
            e_pl[p*8 +: 8] = m_pl[p];
            e_coin[p] = m_out[p];
            if (coin_out[p] && !prev_coin[p]) rises[p]++;
            if (coin_out[p]) hi_cnt[p]++;
        end
        for (int k = 0; k < ND; k++) e_dsw[k*8 +: 8] = m_dsw[k];
        prev_coin = coin_out;
        check("pl", 64'(pl), 64'(e_pl));
        check("coin_out", 64'(coin_out), 64'(e_coin));
        check("dsw", 64'(dsw), 64'(e_dsw));
        check("layout", 64'(layout), 64'(m_layout));
        check("dip_valid", 64'(dip_valid), 64'(m_dipv));
    endtask

    task automatic ioctl_write(input logic [7:0] idx, input logic [26:0] addr, input logic [15:0] data);
        ioctl_wr = 1'b1;
        ioctl_index = idx;
        ioctl_addr = addr;
        ioctl_dout = data;
        $display("cyc %0d ioctl write index=%0d addr=%0h data=%0h", cyc, idx, addr, data);
        tick();
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < FRAME && (cyc % FRAME) != ph; i++) tick();
    endtask

    task automatic clear_obs();
        for (int p = 0; p < NP; p++) begin
            rises[p] = 0;
            hi_cnt[p] = 0;
        end
    endtask

    task automatic idle_all(input int n);
        for (int p = 0; p < NP; p++) begin
            coin_req[p] = 0;
            joy_base[p] = 8'h00;
        end
        repeat (n) tick();
    endtask

    initial begin
        reset = 1'b1;
        ioctl_wr = 1'b0;
        ioctl_index = 8'h00;
        ioctl_addr = 27'h0;
        ioctl_dout = 16'h0;
        vblank = 1'b0;
        joy = '0;
        prev_coin = '0;
        m_vb_d = 0;
        m_layout = 8'h00;
        m_dipv = 0;
        for (int p = 0; p < NP; p++) begin
            joy_base[p] = 8'($urandom);
            coin_req[p] = 0;
            m_pl[p] = 8'h00;
            m_pulse_left[p] = 0;
            m_wait_rel[p] = 0;
            m_lock_left[p] = 0;
            m_out[p] = 0;
        end
        for (int k = 0; k < ND; k++) m_dsw[k] = 8'h00;
        clear_obs();

        // Reset state with live joystick activity
        $display("step: reset");
        repeat (3) tick();
        check("rst_pl", 64'(pl), 64'h0);
        check("rst_coin", 64'(coin_out), 64'h0);
        check("rst_dsw", 64'(dsw), 64'h0);
        check("rst_layout", 64'(layout), 64'h0);
        check("rst_dip_valid", 64'(dip_valid), 64'h0);
        reset = 1'b0;
        tick();

        // DIP load, extra bytes and a far address are ignored
        $display("step: dip load");
        for (int k = 0; k < 8; k++)
            ioctl_write(8'd254, 27'(k), {8'($urandom), 8'(17 * (k + 1))});
        tick();
        check("dsw_load", 64'(dsw), 64'h44332211);
        check("dip_valid_set", 64'(dip_valid), 64'h1);
        ioctl_write(8'd254, 27'h100, 16'h00EE);
        tick();
        check("dsw_far_addr", 64'(dsw), 64'h44332211);

        // Layout selection with U+L held
        $display("step: layout");
        ioctl_write(8'd1, 27'h0, 16'h0001);
        joy_base[0] = 8'h0A;
        repeat (2) tick();
        check("layout_v_UL", 64'(pl[7:0]), 64'h01);
        ioctl_write(8'd1, 27'h0, 16'h0000);
        tick();
        check("layout_h_UL", 64'(pl[7:0]), 64'(exp_pl(16'h000A, 8'h00)));

        // Opposing directions
        $display("step: socd");
        joy_base[0] = 8'h13;
        tick();
        check("socd_LR_fire", 64'(pl[7:0]), 64'h10);
        ioctl_write(8'd1, 27'h0, 16'h0001);
        joy_base[0] = 8'h0C;
        repeat (2) tick();
        check("socd_UD", 64'(pl[3:0]), 64'h0);

        // Randomized traffic
        $display("step: random");
        for (int i = 0; i < 600; i++) begin
            for (int p = 0; p < NP; p++) begin
                joy_base[p] = 8'($urandom);
                if ($urandom_range(7) == 0) coin_req[p] = !coin_req[p];
            end
            reset = ($urandom_range(199) == 0);
            if ($urandom_range(15) == 0) begin
                ioctl_wr = 1'b1;
                case ($urandom_range(2))
                    0: ioctl_index = 8'd1;
                    1: ioctl_index = 8'd254;
                    default: ioctl_index = 8'($urandom);
                endcase
                ioctl_addr = ($urandom_range(3) == 0) ? 27'($urandom) : 27'($urandom_range(7));
                if ($urandom_range(5) == 0) ioctl_addr[26:25] = 2'($urandom);
                ioctl_dout = 16'($urandom);
                $display("cyc %0d ioctl write index=%0d addr=%0h data=%0h reset=%0d",
                         cyc, ioctl_index, ioctl_addr, ioctl_dout, reset);
            end else begin
                ioctl_wr = 1'b0;
            end
            tick();
        end
        reset = 1'b0;
        ioctl_wr = 1'b0;

        // Coin held for 10 frames gives one pulse of CF frames
        $display("step: coin hold");
        idle_all(80);
        wait_phase(8);
        clear_obs();
        coin_req[0] = 1;
        repeat (10 * FRAME) tick();
        check("coin_hold_one_pulse", 64'(rises[0]), 64'd1);
        check("coin_pulse_len", 64'(hi_cnt[0] >= (CF - 1) * FRAME + 1 && hi_cnt[0] <= CF * FRAME), 64'd1);

        // Re-press one frame after release falls inside the lockout
        $display("step: coin lockout");
        wait_phase(8);
        coin_req[0] = 0;
        tick();
        repeat (FRAME - 1) tick();
        coin_req[0] = 1;
        repeat (3) tick();
        coin_req[0] = 0;
        repeat (5) tick();
        check("coin_lock_ignored", 64'(rises[0]), 64'd1);
        repeat (2 * FRAME) tick();
        coin_req[0] = 1;
        repeat (2) tick();
        check("coin_repress_pulse", 64'(rises[0]), 64'd2);
        repeat (4 * FRAME) tick();
        coin_req[0] = 0;

        // Reset in the middle of a pulse, with a DIP write in the same cycle
        $display("step: reset mid pulse");
        idle_all(80);
        wait_phase(8);
        coin_req[1] = 1;
        tick();
        repeat (FRAME) tick();
        reset = 1'b1;
        ioctl_wr = 1'b1;
        ioctl_index = 8'd254;
        ioctl_addr = 27'd2;
        ioctl_dout = 16'h005A;
        tick();
        check("midrst_coin", 64'(coin_out), 64'h0);
        check("midrst_dsw", 64'(dsw), 64'h0);
        check("midrst_dip_valid", 64'(dip_valid), 64'h0);
        reset = 1'b0;
        ioctl_wr = 1'b0;
        clear_obs();
        tick();
        check("postrst_coin_rise", 64'(coin_out[1]), 64'h1);
        repeat (4 * FRAME) tick();
        check("postrst_one_pulse", 64'(rises[1]), 64'd1);
        check("postrst_pulse_len", 64'(hi_cnt[1] >= (CF - 1) * FRAME + 1 && hi_cnt[1] <= CF * FRAME), 64'd1);

        // Independent coins on players 0 and 3 in the same cycle
        $display("step: two players");
        idle_all(80);
        clear_obs();
        coin_req[0] = 1;
        coin_req[3] = 1;
        tick();
        check("coin_p0_p3_same_edge", 64'(coin_out & 4'b1001), 64'(4'b1001));
        repeat (4 * FRAME) tick();
        check("coin_p3_one_pulse", 64'(rises[3]), 64'd1);
        idle_all(40);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
